// File: rtl/vdcmul_8b_seq.sv
// Sequential 8x8 unsigned multiplier: one shared vdcmul_4b, four nibble steps, valid/ready on both sides.
// Optional: define VDCMUL_SEQ_ZERO_SKIP_EN to bypass CALC when either operand is zero.

module vdcmul_2b (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_lo, cross_hi, carry, top;

    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign carry    = cross_lo & cross_hi;
    assign top      = a[1] & b[1];
    assign p        = {top & carry, top ^ carry, cross_lo ^ cross_hi, a[0] & b[0]};
endmodule

module vdcmul_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q_ll, q_hl, q_lh, q_hh;

    vdcmul_2b u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
    vdcmul_2b u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
    vdcmul_2b u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
    vdcmul_2b u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

    // Vertical-crosswise combination of the four 2x2 partial products
    assign p = {4'h0, q_ll} + ({3'h0, {1'b0, q_hl} + {1'b0, q_lh}} << 2) + ({4'h0, q_hh} << 4);
endmodule

module vdcmul_8b_seq #(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        step;
    logic [7:0]        x_q, y_q;
    logic [TAG_W-1:0]  tag_q;
    logic [15:0]       acc, partial, acc_sum;
    logic [3:0]        mul_a, mul_b;
    logic [7:0]        mul_p;
    logic              accept, zero_op;

`ifdef VDCMUL_SEQ_ZERO_SKIP_EN
    assign zero_op = (x == 8'h00) || (y == 8'h00);
`else
    assign zero_op = 1'b0;
`endif

    vdcmul_4b u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                busy  = 1'b1;
                mul_a = step[1] ? x_q[7:4] : x_q[3:0];
                mul_b = step[0] ? y_q[7:4] : y_q[3:0];
                if (step == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        partial = {8'h00, mul_p};
        case (step)
            2'd1, 2'd2: partial = {4'h0, mul_p, 4'h0};
            2'd3:       partial = {mul_p, 8'h00};
            default:    partial = {8'h00, mul_p};
        endcase
    end

    assign acc_sum = acc + partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            step    <= '0;
            acc     <= '0;
            prod    <= '0;
            out_tag <= '0;
            x_q     <= '0;
            y_q     <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            x_q   <= x;
            y_q   <= y;
            tag_q <= in_tag;
            acc   <= '0;
            step  <= '0;
            if (zero_op) begin
                prod    <= '0;
                out_tag <= in_tag;
            end
        end else if (state == CALC) begin
            acc  <= acc_sum;
            step <= step + 2'd1;
            if (step == 2'd3) begin
                prod    <= acc_sum;
                out_tag <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_vdcmul_8b_seq.sv
// Directed, table-driven bench for vdcmul_8b_seq: latency, backpressure, back-to-back and mid-CALC reset.
// Zero-operand latency follows VDCMUL_SEQ_ZERO_SKIP_EN.

module tb_vdcmul_8b_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x, y;
    logic [1:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic [1:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vdcmul_8b_seq #(.TAG_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [1:0]  tag;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef VDCMUL_SEQ_ZERO_SKIP_EN
        return (a == 8'h00 || b == 8'h00) ? 1 : 5;
`else
        return 5;
`endif
    endfunction

    // Called and returns at a negedge; operands are scrambled after accept to prove they are latched.
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] t,
                          input logic [15:0] e, input string nm);
        int n;
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        in_tag    = t;
        out_ready = 1'b1;
        chk({nm, " in_ready_idle"}, int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x        = ~a;
        y        = ~b;
        in_tag   = ~t;
        chk({nm, " busy_after_accept"}, int'(busy), 1);
        chk({nm, " in_ready_after_accept"}, int'(in_ready), 0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, exp_lat(a, b));
        chk({nm, " prod"}, int'(prod), int'(e));
        chk({nm, " out_tag"}, int'(out_tag), int'(t));
        @(posedge clk);
        @(negedge clk);
        chk({nm, " out_valid_clear"}, int'(out_valid), 0);
        chk({nm, " in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [15:0] hold_prod;
        logic [1:0]  hold_tag;
        logic [15:0] b2b_exp[3];
        logic [7:0]  b2b_x[3];
        logic [7:0]  b2b_y[3];
        int          idx, res, last, cyc, n;
        logic        acc;

        vecs[0] = '{8'h12, 8'h34, 2'd2, 16'h03A8};
        vecs[1] = '{8'hFF, 8'hFF, 2'd1, 16'hFE01};
        vecs[2] = '{8'h0F, 8'hF0, 2'd3, 16'h0E10};
        vecs[3] = '{8'hF0, 8'h0F, 2'd0, 16'h0E10};
        vecs[4] = '{8'h9C, 8'h37, 2'd1, 16'h2184};
        vecs[5] = '{8'h7F, 8'h81, 2'd2, 16'h3FFF};
        vecs[6] = '{8'h00, 8'h7F, 2'd3, 16'h0000};
        vecs[7] = '{8'hC3, 8'h00, 2'd1, 16'h0000};
        vecs[8] = '{8'h01, 8'hFF, 2'd0, 16'h00FF};

        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset prod", int'(prod), 0);
        chk("reset out_tag", int'(out_tag), 0);

        for (int i = 0; i < 9; i++)
            do_txn(vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].prod, $sformatf("vec%0d", i));

        // Backpressure: hold result for 10 cycles
        in_valid = 1'b1; x = 8'h5A; y = 8'hA5; in_tag = 2'd2; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp latency", n, 5);
        chk("bp prod", int'(prod), 16'h3A02);
        hold_prod = prod;
        hold_tag  = out_tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp out_valid", int'(out_valid), 1);
            chk("bp prod hold", int'(prod), int'(hold_prod));
            chk("bp tag hold", int'(out_tag), int'(hold_tag));
            chk("bp in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp out_valid after", int'(out_valid), 0);
        chk("bp in_ready after", int'(in_ready), 1);
        chk("bp busy after", int'(busy), 0);

        // Back-to-back with in_valid held high
        b2b_x = '{8'h01, 8'h80, 8'hAB};
        b2b_y = '{8'h01, 8'h02, 8'hCD};
        b2b_exp = '{16'h0001, 16'h0100, 16'h88EF};
        idx = 0; res = 0; last = 0; cyc = 0;
        in_valid = 1'b1; x = b2b_x[0]; y = b2b_y[0]; in_tag = 2'd1; out_ready = 1'b1;
        while (res < 3 && cyc < 60) begin
            if (out_valid) begin
                chk($sformatf("b2b prod%0d", res), int'(prod), int'(b2b_exp[res]));
                res++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (idx > 0) chk("b2b accept spacing", cyc - last, 6);
                last = cyc;
                idx++;
                if (idx < 3) begin
                    x = b2b_x[idx];
                    y = b2b_y[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b result count", res, 3);

        // Reset while step==2; the transaction must vanish
        in_valid = 1'b1; x = 8'h55; y = 8'h66; in_tag = 2'd3; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", int'(busy), 0);
        chk("midreset prod", int'(prod), 0);
        chk("midreset in_ready", int'(in_ready), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) n++;
            @(negedge clk);
        end
        chk("midreset no out_valid", n, 0);
        do_txn(8'h10, 8'h10, 2'd1, 16'h0100, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
